// File: rtl/sw_target_feeder_if.sv
// sw_target_feeder_if
//   Groups the target base stream (s_*) and the score result handshake
//   (score_*) of sw_target_feeder.
//   master : target source / score consumer (testbench or upstream logic)
//   slave  : sw_target_feeder
//   s_valid/s_data/s_last/s_ready : base beats, A=00 G=01 T=10 C=11
//   score_valid/score/score_trunc/score_ready : unbiased best score result
interface sw_target_feeder_if #(
  parameter int SCORE_WIDTH = 12
);
  logic                   s_valid;
  logic [1:0]             s_data;
  logic                   s_last;
  logic                   s_ready;
  logic                   score_valid;
  logic [SCORE_WIDTH-1:0] score;
  logic                   score_trunc;
  logic                   score_ready;

  modport master (
    output s_valid, s_data, s_last, score_ready,
    input  s_ready, score_valid, score, score_trunc
  );

  modport slave (
    input  s_valid, s_data, s_last, score_ready,
    output s_ready, score_valid, score, score_trunc
  );
endinterface

// File: rtl/sw_target_feeder.sv
// sw_target_feeder
//   Buffers one target sequence, streams it into the first PE of a
//   Smith-Waterman systolic array, waits for the last PE's result and
//   presents the unbiased best score.
//   clk, rst                 : clock, synchronous active-high reset
//   bus (slave)              : base stream in, score result out
//   pe_en, pe_data           : registered base feed to the first PE
//   pe_M, pe_I, pe_High      : boundary scores, constant biased zero
//   res_vld, res_high        : result pulse and High_out of the last PE
module sw_target_feeder #(
  parameter int SCORE_WIDTH = 12,
  parameter int MAX_LEN     = 256,
  parameter int ADDR_WIDTH  = 8
) (
  input  logic                   clk,
  input  logic                   rst,
  sw_target_feeder_if.slave      bus,
  output logic                   pe_en,
  output logic [1:0]             pe_data,
  output logic [SCORE_WIDTH-1:0] pe_M,
  output logic [SCORE_WIDTH-1:0] pe_I,
  output logic [SCORE_WIDTH-1:0] pe_High,
  input  logic                   res_vld,
  input  logic [SCORE_WIDTH-1:0] res_high
);

  localparam logic [SCORE_WIDTH-1:0] ZERO    = SCORE_WIDTH'(2**(SCORE_WIDTH-1));
  localparam logic [ADDR_WIDTH:0]    LEN_MAX = (ADDR_WIDTH+1)'(MAX_LEN);
  localparam logic [ADDR_WIDTH:0]    LEN_ONE = (ADDR_WIDTH+1)'(1);
  localparam logic [ADDR_WIDTH-1:0]  PTR_ONE = ADDR_WIDTH'(1);

  typedef enum logic [1:0] {LOAD, STREAM, DRAIN, HOLD} state_t;

  state_t                 state, state_nxt;
  logic [1:0]             buffer [0:MAX_LEN-1];
  logic [ADDR_WIDTH-1:0]  wr_ptr;
  logic [ADDR_WIDTH:0]    len;
  logic [ADDR_WIDTH:0]    rd_cnt;
  logic                   trunc;
  logic [SCORE_WIDTH-1:0] score_q;
  logic                   score_trunc_q;
  logic                   beat;
  logic                   full;
  logic                   last_rd;

  assign beat    = bus.s_valid && bus.s_ready;
  assign full    = (len == LEN_MAX);
  assign last_rd = ((rd_cnt + LEN_ONE) == len);

  // State register
  always_ff @(posedge clk) begin
    if (rst) state <= LOAD;
    else     state <= state_nxt;
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    unique case (state)
      LOAD:    if (beat && bus.s_last) state_nxt = STREAM;
      STREAM:  if (last_rd)            state_nxt = DRAIN;
      DRAIN:   if (res_vld)            state_nxt = HOLD;
      HOLD:    if (bus.score_ready)    state_nxt = LOAD;
      default:                         state_nxt = LOAD;
    endcase
  end

  // Outputs; s_ready is held low while rst is asserted so no beat is
  // accepted in the reset cycle whatever the pre-reset state was.
  always_comb begin
    bus.s_ready     = (state == LOAD) && !rst;
    bus.score_valid = (state == HOLD);
    bus.score       = score_q;
    bus.score_trunc = score_trunc_q;
    pe_M            = ZERO;
    pe_I            = ZERO;
    pe_High         = ZERO;
  end

  // Target storage; beats past MAX_LEN are accepted but dropped.
  always_ff @(posedge clk) begin
    if (state == LOAD && beat && !full) buffer[wr_ptr] <= bus.s_data;
  end

  // Datapath: load counters, registered PE feed, score capture
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr        <= '0;
      len           <= '0;
      trunc         <= 1'b0;
      rd_cnt        <= '0;
      pe_en         <= 1'b0;
      pe_data       <= '0;
      score_q       <= '0;
      score_trunc_q <= 1'b0;
    end else begin
      pe_en   <= 1'b0;
      pe_data <= '0;
      unique case (state)
        LOAD: begin
          rd_cnt <= '0;
          if (beat && !full) begin
            wr_ptr <= wr_ptr + PTR_ONE;
            len    <= len + LEN_ONE;
            if (!bus.s_last && (len + LEN_ONE) == LEN_MAX) trunc <= 1'b1;
          end
        end
        STREAM: begin
          pe_en   <= 1'b1;
          pe_data <= buffer[rd_cnt[ADDR_WIDTH-1:0]];
          rd_cnt  <= rd_cnt + LEN_ONE;
        end
        DRAIN: begin
          if (res_vld) begin
            score_q       <= (res_high >= ZERO) ? (res_high - ZERO) : '0;
            score_trunc_q <= trunc;
          end
        end
        HOLD: begin
          if (bus.score_ready) begin
            wr_ptr <= '0;
            len    <= '0;
            trunc  <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
